vrb_burst_master: RTL and testbench

- VRB initiator that drives the memory-subsystem external cmd/rsp port (the slave port used to preload or inspect instruction and data memory while the CPU is held).
- A host-side controller issues a burst request: base address, word count and direction.
- Writes pull words from an input stream. Reads push returned words to an output stream.
- One outstanding command at a time. Each command is held until its response arrives or a timeout expires.

---
 rtl/vrb_burst_master_if.sv | 24 ++
 rtl/vrb_burst_master.sv | 185 ++++++++++++++++++
 tb/tb_vrb_burst_master.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vrb_burst_master_if.sv
// rtl/vrb_burst_master_if.sv - VRB command/response port bundle
interface vrb_burst_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cmd_valid;
  logic [AW-1:0]   cmd_addr;
  logic            cmd_read;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic            rsp_valid;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask,
    input  rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask,
    output rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/vrb_burst_master.sv
// rtl/vrb_burst_master.sv - VRB burst initiator: one outstanding command, stream in/out
module vrb_burst_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LENW    = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_write,
  input  logic [AW-1:0]     i_base_addr,
  input  logic [LENW-1:0]   i_len,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_timeout,
  output logic [LENW-1:0]   o_count,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DW-1:0]     i_wr_data,
  input  logic [DW/8-1:0]   i_wr_mask,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DW-1:0]     o_rd_data,
  vrb_burst_master_if.master vrb
);

  localparam logic [AW-1:0] STEP      = AW'(DW / 8);
  localparam logic [15:0]   WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CMD, S_PUSH, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [AW-1:0]     r_addr;
  logic [LENW-1:0]   r_remaining;
  logic              r_dir;
  logic [15:0]       r_wait;
  logic [LENW-1:0]   r_count;
  logic              r_err;
  logic              r_timeout;
  logic              r_done;
  logic              r_wr_ready;
  logic              r_rd_valid;
  logic [DW-1:0]     r_rd_data;
  logic              r_cmd_valid;
  logic              r_cmd_read;
  logic [DW-1:0]     r_cmd_wdata;
  logic [DW/8-1:0]   r_cmd_wmask;

  logic w_accept;
  logic w_fetch_hs;
  logic w_rsp_ok;
  logic w_rsp_err;
  logic w_tmo;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_fetch_hs = 1'b0;
    w_rsp_ok   = 1'b0;
    w_rsp_err  = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          if (i_len == '0)  w_next = S_DONE;
          else if (i_write) w_next = S_FETCH;
          else              w_next = S_CMD;
        end
      end
      S_FETCH: begin
        if (i_wr_valid && r_wr_ready) begin
          w_fetch_hs = 1'b1;
          w_next     = S_CMD;
        end
      end
      S_CMD: begin
        // A response in the same cycle as the last wait slot wins over the timeout
        if (vrb.rsp_valid) begin
          if (vrb.rsp_err) begin
            w_rsp_err = 1'b1;
            w_next    = S_DONE;
          end else begin
            w_rsp_ok = 1'b1;
            if (!r_dir)                        w_next = S_PUSH;
            else if (r_remaining == LENW'(1))  w_next = S_DONE;
            else                               w_next = S_FETCH;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_DONE;
        end
      end
      S_PUSH: begin
        if (i_rd_ready) begin
          if (r_remaining == '0) w_next = S_DONE;
          else                   w_next = S_CMD;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state itself
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_dir       <= 1'b0;
      r_wait      <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      r_done      <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_read  <= 1'b0;
      r_cmd_wdata <= '0;
      r_cmd_wmask <= '0;
    end else begin
      r_cmd_valid <= (w_next == S_CMD);
      r_wr_ready  <= (w_next == S_FETCH);
      r_rd_valid  <= (w_next == S_PUSH);
      r_done      <= (w_next == S_DONE);

      if (r_state != S_CMD)  r_wait <= '0;
      else if (!vrb.rsp_valid) r_wait <= r_wait + 16'd1;

      if (w_accept) begin
        r_addr      <= i_base_addr;
        r_remaining <= i_len;
        r_dir       <= i_write;
        r_cmd_read  <= ~i_write;
        r_err       <= 1'b0;
        r_timeout   <= 1'b0;
        r_count     <= '0;
        if (!i_write) begin
          r_cmd_wdata <= '0;
          r_cmd_wmask <= '0;
        end
      end

      if (w_fetch_hs) begin
        r_cmd_wdata <= i_wr_data;
        r_cmd_wmask <= i_wr_mask;
      end

      if (w_rsp_ok) begin
        r_count     <= r_count + LENW'(1);
        r_addr      <= r_addr + STEP;
        r_remaining <= r_remaining - LENW'(1);
        if (!r_dir) r_rd_data <= vrb.rsp_rdata;
      end

      if (w_rsp_err) r_err     <= 1'b1;
      if (w_tmo)     r_timeout <= 1'b1;
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_timeout     = r_timeout;
  assign o_count       = r_count;
  assign o_wr_ready    = r_wr_ready;
  assign o_rd_valid    = r_rd_valid;
  assign o_rd_data     = r_rd_data;
  assign vrb.cmd_valid = r_cmd_valid;
  assign vrb.cmd_addr  = r_addr;
  assign vrb.cmd_read  = r_cmd_read;
  assign vrb.cmd_wdata = r_cmd_wdata;
  assign vrb.cmd_wmask = r_cmd_wmask;

endmodule

// File: tb/tb_vrb_burst_master.sv
// tb/tb_vrb_burst_master.sv - randomized scoreboard bench for vrb_burst_master
module tb_vrb_burst_master;
  localparam int AW = 32, DW = 32, LENW = 16, TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            i_start = 0, i_write = 0;
  logic [AW-1:0]   i_base_addr = '0;
  logic [LENW-1:0] i_len = '0;
  logic            o_busy, o_done, o_err, o_timeout;
  logic [LENW-1:0] o_count;
  logic            i_wr_valid = 0;
  logic            o_wr_ready;
  logic [DW-1:0]   i_wr_data = '0;
  logic [3:0]      i_wr_mask = '0;
  logic            o_rd_valid;
  logic            i_rd_ready = 0;
  logic [DW-1:0]   o_rd_data;

  vrb_burst_master_if #(.AW(AW), .DW(DW)) vrb ();

  vrb_burst_master #(.AW(AW), .DW(DW), .LENW(LENW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_start(i_start), .i_write(i_write), .i_base_addr(i_base_addr), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_timeout(o_timeout), .o_count(o_count),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data), .i_wr_mask(i_wr_mask),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
    .vrb(vrb.master)
  );

  typedef struct {logic [31:0] addr; logic rd; logic [31:0] wdata; logic [3:0] wmask; int hi_len; int pops;} cmd_t;
  typedef struct {bit respond; int delay; bit err; logic [31:0] rdata;} rsp_t;
  typedef struct {bit err; bit tmo; int count;} done_t;

  cmd_t        exp_cmd_q[$];
  logic [31:0] exp_rd_q[$];
  done_t       exp_done_q[$];
  rsp_t        plan[$];
  rsp_t        rsp_q[$];
  logic [31:0] wr_data_a[$];
  logic [3:0]  wr_mask_a[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int rd_pops = 0;
  int hold_rd = 0;
  bit rand_ready = 1;
  bit noise_en = 1;
  int last_rsp_cyc = -10;
  int last_done_cyc = -10;
  int first_cmd_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_rsp(bit respond, int delay, bit err, logic [31:0] rdata);
    rsp_t r;
    r.respond = respond; r.delay = delay; r.err = err; r.rdata = rdata;
    plan.push_back(r);
  endtask

  // Reference: walk the response plan word by word and stop at the first error or silence
  task automatic model_burst(input bit wr, input logic [31:0] base, input int len, output done_t d);
    cmd_t c;
    logic [31:0] a;
    a = base;
    d.err = 0; d.tmo = 0; d.count = 0;
    for (int i = 0; i < len; i++) begin
      c.addr   = a;
      c.rd     = !wr;
      c.wdata  = wr ? wr_data_a[i] : 32'h0;
      c.wmask  = wr ? wr_mask_a[i] : 4'h0;
      c.hi_len = plan[i].respond ? plan[i].delay + 1 : TMO;
      c.pops   = wr ? -1 : i;
      exp_cmd_q.push_back(c);
      if (!plan[i].respond) begin d.tmo = 1; break; end
      if (plan[i].err)      begin d.err = 1; break; end
      d.count++;
      if (!wr) exp_rd_q.push_back(plan[i].rdata);
      a = a + 32'd4;
    end
    exp_done_q.push_back(d);
  endtask

  task automatic run_burst(bit wr, logic [31:0] base, int len);
    done_t d;
    int n, t, start_cyc;
    model_burst(wr, base, len, d);
    n = exp_cmd_q.size();
    rsp_q = plan;
    rd_pops = 0;
    first_cmd_cyc = -1;
    @(posedge clk); #1;
    i_start = 1; i_write = wr; i_base_addr = base; i_len = 16'(len);
    start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 0; i_write = 1'($urandom); i_base_addr = $urandom; i_len = 16'($urandom);
    if (wr) begin
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        i_wr_valid = 1; i_wr_data = wr_data_a[k]; i_wr_mask = wr_mask_a[k];
        t = 0;
        while (!o_wr_ready && t < 200) begin @(posedge clk); #1; t++; end
        if (t >= 200) begin
          checks++; errors++;
          $display("FAIL wr_ready_wait actual=timeout required=handshake");
        end
        @(posedge clk); #1;
        i_wr_valid = 0; i_wr_data = $urandom;
      end
    end
    t = 0;
    while (exp_done_q.size() != 0 && t < 300) begin @(posedge clk); t++; end
    if (t >= 300) begin
      checks++; errors++;
      $display("FAIL done_wait actual=timeout required=o_done");
      exp_done_q.delete(); exp_cmd_q.delete(); exp_rd_q.delete();
    end
    if (len == 0) chk("zero_len_done_cycle", 128'(last_done_cyc - start_cyc), 128'(1));
    else if (!wr) chk("first_cmd_cycle", 128'(first_cmd_cyc - start_cyc), 128'(1));
    repeat (2) @(posedge clk);
    #1;
    chk("hold_count", o_count, 128'(d.count));
    chk("hold_flags", {o_busy, o_err, o_timeout}, {1'b0, d.err, d.tmo});
    plan.delete(); wr_data_a.delete(); wr_mask_a.delete();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ctl"}, {o_busy, o_done, o_err, o_timeout, o_wr_ready, o_rd_valid, vrb.cmd_valid, vrb.cmd_read}, 0);
    chk({tag, "_count"}, o_count, 0);
    chk({tag, "_rd_data"}, o_rd_data, 0);
    chk({tag, "_cmd_addr"}, vrb.cmd_addr, 0);
    chk({tag, "_cmd_wdata"}, {vrb.cmd_wdata, vrb.cmd_wmask}, 0);
  endtask

  // Responder: answers each command after its planned delay; stray pulses while no command
  initial begin
    bit act = 0, answered = 0;
    int w = 0;
    rsp_t p;
    vrb.rsp_valid = 0; vrb.rsp_err = 0; vrb.rsp_rdata = '0;
    p.respond = 0; p.delay = 0; p.err = 0; p.rdata = '0;
    forever begin
      @(posedge clk); #1;
      vrb.rsp_valid = 0; vrb.rsp_err = 1'($urandom); vrb.rsp_rdata = $urandom;
      if (vrb.cmd_valid) begin
        if (!act) begin
          act = 1; w = 0; answered = 0;
          if (rsp_q.size() > 0) p = rsp_q.pop_front();
          else p.respond = 0;
        end
        if (p.respond && !answered && w == p.delay) begin
          vrb.rsp_valid = 1; vrb.rsp_err = p.err; vrb.rsp_rdata = p.rdata;
          answered = 1; last_rsp_cyc = cyc;
        end
        w++;
      end else begin
        act = 0;
        if ($urandom_range(0, 5) == 0) vrb.rsp_valid = 1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (o_rd_valid && hold_rd > 0) begin i_rd_ready = 0; hold_rd--; end
      else i_rd_ready = rand_ready ? 1'($urandom) : 1'b1;
    end
  end

  // Start pulses while busy must be ignored
  initial begin
    bit on = 0;
    forever begin
      @(posedge clk); #2;
      if (on) begin i_start = 0; on = 0; end
      else if (noise_en && o_busy && !o_done && $urandom_range(0, 5) == 0) begin
        i_start = 1; i_write = 1'($urandom); i_base_addr = $urandom; i_len = 16'($urandom_range(1, 9));
        on = 1;
      end
    end
  end

  initial begin
    bit pv = 0;
    int hi = 0;
    cmd_t cur;
    cur.addr = '0; cur.rd = 0; cur.wdata = '0; cur.wmask = '0; cur.hi_len = 0; cur.pops = -1;
    forever begin
      @(negedge clk);
      if (vrb.cmd_valid) begin
        if (!pv) begin
          hi = 0;
          if (exp_cmd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cmd actual=%0h required=none", vrb.cmd_addr);
            cur.hi_len = 0; cur.pops = -1;
          end else begin
            cur = exp_cmd_q.pop_front();
            chk("cmd_addr", vrb.cmd_addr, cur.addr);
            chk("cmd_read", vrb.cmd_read, cur.rd);
            chk("cmd_wdata", {vrb.cmd_wdata, vrb.cmd_wmask}, {cur.wdata, cur.wmask});
            if (cur.pops >= 0) chk("cmd_after_pop", 128'(rd_pops), 128'(cur.pops));
            if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
          end
        end else begin
          chk("cmd_stable", {vrb.cmd_addr, vrb.cmd_read}, {cur.addr, cur.rd});
        end
        hi++;
      end else if (pv && rst_n && cur.hi_len > 0) begin
        chk("cmd_valid_len", 128'(hi), 128'(cur.hi_len));
      end
      pv = vrb.cmd_valid;
    end
  end

  initial begin
    bit pv = 0, pstall = 0;
    logic [31:0] pd = '0;
    forever begin
      @(negedge clk);
      if (o_rd_valid && !pv) chk("rd_latency", 128'(cyc), 128'(last_rsp_cyc + 1));
      if (o_rd_valid && pstall) chk("rd_data_held", o_rd_data, pd);
      if (o_rd_valid && i_rd_ready) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd actual=%0h required=none", o_rd_data);
        end else chk("rd_data", o_rd_data, exp_rd_q.pop_front());
        rd_pops++;
      end
      pstall = o_rd_valid && !i_rd_ready;
      pd = o_rd_data;
      pv = o_rd_valid;
    end
  end

  initial begin
    bit pd = 0;
    done_t d;
    forever begin
      @(negedge clk);
      if (o_done) begin
        chk("done_pulse", pd, 0);
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          d = exp_done_q.pop_front();
          chk("done_err", o_err, d.err);
          chk("done_timeout", o_timeout, d.tmo);
          chk("done_count", o_count, 128'(d.count));
          chk("done_cmds_left", 128'(exp_cmd_q.size()), 0);
          chk("done_rd_left", 128'(exp_rd_q.size()), 0);
          last_done_cyc = cyc;
        end
      end
      pd = o_done;
    end
  end

  initial begin
    int len, t;
    bit wr;
    logic [31:0] base;
    done_t dd;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1;

    wr_data_a = '{32'h11111111, 32'h22222222, 32'h33333333};
    wr_mask_a = '{4'hF, 4'hF, 4'hF};
    repeat (3) add_rsp(1, 0, 0, 32'h0);
    run_burst(1, 32'h100, 3);

    hold_rd = 3; rand_ready = 0;
    add_rsp(1, 0, 0, 32'hDEADBEEF);
    add_rsp(1, 1, 0, 32'hCAFEF00D);
    run_burst(0, 32'h2000, 2);
    rand_ready = 1;

    add_rsp(1, 1, 0, 32'hA5A5A5A5);
    add_rsp(1, 0, 1, 32'h0);
    add_rsp(1, 0, 0, 32'h1);
    add_rsp(1, 0, 0, 32'h2);
    run_burst(0, 32'h4000, 4);

    add_rsp(0, 0, 0, 32'h0);
    add_rsp(0, 0, 0, 32'h0);
    run_burst(0, 32'h3000, 2);

    run_burst(1, 32'h40, 0);
    run_burst(0, 32'h80, 0);

    add_rsp(1, 2, 0, 32'h01234567);
    add_rsp(1, 0, 0, 32'h89ABCDEF);
    run_burst(0, 32'hFFFFFFFC, 2);

    for (int r = 0; r < 30; r++) begin
      wr   = 1'($urandom);
      len  = $urandom_range(0, 5);
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 : ($urandom & 32'hFFFFFFFC);
      for (int i = 0; i < len; i++) begin
        add_rsp($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom);
        wr_data_a.push_back($urandom);
        wr_mask_a.push_back(4'($urandom));
      end
      run_burst(wr, base, len);
    end

    // Reset while the second read command is outstanding
    noise_en = 0;
    repeat (3) @(posedge clk);
    add_rsp(1, 0, 0, 32'h5A5A1234);
    add_rsp(0, 0, 0, 32'h0);
    add_rsp(1, 0, 0, 32'h0);
    model_burst(0, 32'h7000, 3, dd);
    exp_done_q.delete();
    rsp_q = plan; plan.delete();
    rd_pops = 0;
    @(posedge clk); #1;
    i_start = 1; i_write = 0; i_base_addr = 32'h7000; i_len = 16'd3;
    @(posedge clk); #1;
    i_start = 0;
    t = 0;
    while (!(vrb.cmd_valid && rd_pops == 1) && t < 100) begin @(posedge clk); #1; t++; end
    chk("reset_test_reached", 128'(t < 100), 1);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midreset");
    chk("midreset_cmds_left", 128'(exp_cmd_q.size()), 0);
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_reset_idle", {o_busy, vrb.cmd_valid, o_count}, 0);
    exp_cmd_q.delete(); exp_rd_q.delete(); rsp_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=hang required=finish");
    $fatal(1, "global timeout");
  end

endmodule
